// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_pkg                                                     |
// | Brief   : Shared types and default widths for the writeback unit.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wb_pkg;

   localparam int c_ADDR_WIDTH = 5;
   localparam int c_DATA_WIDTH = 64;

   typedef enum logic [1:0] {
      LS_BYTE   = 2'd0,
      LS_HALF   = 2'd1,
      LS_WORD   = 2'd2,
      LS_DOUBLE = 2'd3
   } load_size_e;

   typedef struct packed {
      logic [c_ADDR_WIDTH-1:0] rd;
      logic [c_DATA_WIDTH-1:0] data;
   } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wb_load_extend                                             |
// | Brief   : Sign/zero extension of load data to DATA_WIDTH.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_load_extend
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = c_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  load_size_e            size,
   input  logic                  is_unsigned,
   output logic [DATA_WIDTH-1:0] ext
);

   always_comb begin
      ext = data;
      unique case (size)
         LS_BYTE: begin
            if (is_unsigned) ext = DATA_WIDTH'(data[7:0]);
            else             ext = DATA_WIDTH'($signed(data[7:0]));
         end
         LS_HALF: begin
            if (is_unsigned) ext = DATA_WIDTH'(data[15:0]);
            else             ext = DATA_WIDTH'($signed(data[15:0]));
         end
         LS_WORD: begin
            if (is_unsigned) ext = DATA_WIDTH'(data[31:0]);
            else             ext = DATA_WIDTH'($signed(data[31:0]));
         end
         LS_DOUBLE: ext = data;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : writeback_unit                                             |
// | Brief   : Result queue feeding the register file write port, with    |
// |           load extension on entry. Define WB_BYPASS_EN to add two    |
// |           bypass query ports matching pending writes.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module writeback_unit
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = c_ADDR_WIDTH,
   parameter int DATA_WIDTH = c_DATA_WIDTH,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_is_load,
   input  logic [1:0]            in_size,
   input  logic                  in_unsigned,
   input  logic                  hold,
   input  logic                  flush,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic [31:0]           retired
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_WIDTH-1:0] rs1_addr,
   input  logic [ADDR_WIDTH-1:0] rs2_addr,
   output logic                  rs1_hit,
   output logic                  rs2_hit,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic [DATA_WIDTH-1:0] rs2_data
`endif
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t               r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic [31:0]          r_retired;

   logic [DATA_WIDTH-1:0] w_ext_data;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic                  w_push;
   logic                  w_pop;
   entry_t                w_head;

   wb_load_extend #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_load_extend (
      .data        (in_data),
      .size        (load_size_e'(in_size)),
      .is_unsigned (in_unsigned),
      .ext         (w_ext_data)
   );

   // flush blocks both the pop and the concurrent push
   always_comb begin
      w_push_data  = in_is_load ? w_ext_data : in_data;
      in_ready     = (r_count < c_CNT_W'(DEPTH));
      w_head       = r_mem[r_rd_ptr];
      w_pop        = (r_count != '0) && !hold && !flush;
      w_push       = in_valid && in_ready && !flush;
      write_enable = w_pop && (w_head.rd != '0);
      write_addr   = w_head.rd;
      write_data   = w_head.data;
      retired      = r_retired;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{rd: in_rd, data: w_push_data};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_retired <= '0;
      end else if (flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_retired <= r_retired + 32'd1;
         end
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      logic [c_PTR_W-1:0] idx;
      idx      = '0;
      rs1_hit  = 1'b0;
      rs2_hit  = 1'b0;
      rs1_data = '0;
      rs2_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = r_rd_ptr + c_PTR_W'(i);
         if ((c_CNT_W'(i) < r_count) && (r_mem[idx].rd != '0)) begin
            if (r_mem[idx].rd == rs1_addr) begin
               rs1_hit  = 1'b1;
               rs1_data = r_mem[idx].data;
            end
            if (r_mem[idx].rd == rs2_addr) begin
               rs2_hit  = 1'b1;
               rs2_data = r_mem[idx].data;
            end
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_writeback_unit                                          |
// | Brief   : Directed and random checks of writeback_unit vs a queue    |
// |           model.                                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_writeback_unit;
   import wb_pkg::*;

   localparam int AW    = 5;
   localparam int DW    = 64;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rd = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_is_load = 1'b0;
   logic [1:0]    in_size = '0;
   logic          in_unsigned = 1'b0;
   logic          hold = 1'b0;
   logic          flush = 1'b0;
   logic          write_enable;
   logic [AW-1:0] write_addr;
   logic [DW-1:0] write_data;
   logic [31:0]   retired;
`ifdef WB_BYPASS_EN
   logic [AW-1:0] rs1_addr = '0;
   logic [AW-1:0] rs2_addr = '0;
   logic          rs1_hit, rs2_hit;
   logic [DW-1:0] rs1_data, rs2_data;
`endif

   writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_rd        (in_rd),
      .in_data      (in_data),
      .in_is_load   (in_is_load),
      .in_size      (in_size),
      .in_unsigned  (in_unsigned),
      .hold         (hold),
      .flush        (flush),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .retired      (retired)
`ifdef WB_BYPASS_EN
      ,
      .rs1_addr     (rs1_addr),
      .rs2_addr     (rs2_addr),
      .rs1_hit      (rs1_hit),
      .rs2_hit      (rs2_hit),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_retired = '0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] r0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Keep the low 8/16/32 bits; a set top bit in signed mode subtracts 2^n.
   function automatic logic [63:0] extend(input logic [63:0] d, input bit ld,
                                          input logic [1:0] sz, input bit u);
      longint unsigned w, v;
      if (!ld || sz == 2'd3) return d;
      w = 64'd1 << (8 << sz);
      v = d % w;
      if (!u && v >= w / 2) v = v - w;
      return v;
   endfunction

   task automatic set_inputs(input bit v, input logic [AW-1:0] rd, input logic [63:0] d,
                             input bit ld, input logic [1:0] sz, input bit u,
                             input bit h, input bit f);
      in_valid = v; in_rd = rd; in_data = d; in_is_load = ld;
      in_size = sz; in_unsigned = u; hold = h; flush = f;
   endtask

   task automatic compare_outputs();
      bit exp_we;
      exp_we = (mq.size() > 0) && !hold && !flush && (mq[0].rd != 0);
      check("in_ready", in_ready, mq.size() < DEPTH);
      check("write_enable", write_enable, exp_we);
      if (exp_we) begin
         check("write_addr", write_addr, mq[0].rd);
         check("write_data", write_data, mq[0].data);
      end
      check("retired", retired, m_retired);
`ifdef WB_BYPASS_EN
      begin
         bit e1, e2;
         logic [63:0] d1, d2;
         e1 = 0; e2 = 0; d1 = 0; d2 = 0;
         foreach (mq[i]) begin
            if (mq[i].rd != 0 && mq[i].rd == rs1_addr) begin e1 = 1; d1 = mq[i].data; end
            if (mq[i].rd != 0 && mq[i].rd == rs2_addr) begin e2 = 1; d2 = mq[i].data; end
         end
         check("rs1_hit", rs1_hit, e1);
         check("rs2_hit", rs2_hit, e2);
         if (e1) check("rs1_data", rs1_data, d1);
         if (e2) check("rs2_data", rs2_data, d2);
      end
`endif
   endtask

   task automatic model_update();
      bit can_push;
      can_push = mq.size() < DEPTH;
      if (flush) begin
         mq.delete();
      end else begin
         if (mq.size() > 0 && !hold) begin
            void'(mq.pop_front());
            m_retired++;
         end
         if (in_valid && can_push)
            mq.push_back('{in_rd, extend(in_data, in_is_load, in_size, in_unsigned)});
      end
   endtask

   task automatic step(input bit v, input logic [AW-1:0] rd, input logic [63:0] d,
                       input bit ld, input logic [1:0] sz, input bit u,
                       input bit h, input bit f);
      set_inputs(v, rd, d, ld, sz, u, h, f);
      @(negedge clk);
      compare_outputs();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #3;
      check("rst_in_ready", in_ready, 1);
      check("rst_write_enable", write_enable, 0);
      check("rst_retired", retired, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // signed then unsigned byte load, one-cycle latency
      step(1, 5, 64'h80, 1, 0, 0, 0, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("lb_s_we", write_enable, 1);
      check("lb_s_addr", write_addr, 5);
      check("lb_s_data", write_data, 64'hFFFF_FFFF_FFFF_FF80);
      idle();
      step(1, 5, 64'h80, 1, 0, 1, 0, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("lb_u_data", write_data, 64'h80);
      idle();

      // hold fills the queue, release drains in order
      r0 = retired;
      step(1, 1, 64'h111, 0, 3, 0, 1, 0);
      step(1, 2, 64'h222, 0, 3, 0, 1, 0);
      set_inputs(1, 3, 64'h333, 0, 3, 0, 1, 0);
      #1;
      check("hold_full_ready", in_ready, 0);
      step(1, 3, 64'h333, 0, 3, 0, 1, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("drain_addr0", write_addr, 1);
      idle();
      #1;
      check("drain_addr1", write_addr, 2);
      idle();
      check("drain_retired", retired, r0 + 32'd2);

      // rd 0 is popped silently
      r0 = retired;
      step(1, 0, 64'h1234, 0, 3, 0, 0, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("rd0_we", write_enable, 0);
      idle();
      check("rd0_retired", retired, r0 + 32'd1);

`ifdef WB_BYPASS_EN
      step(1, 7, 64'h11, 0, 3, 0, 1, 0);
      step(1, 7, 64'h22, 0, 3, 0, 1, 0);
      rs1_addr = 7; rs2_addr = 0;
      #1;
      check("byp_hit", rs1_hit, 1);
      check("byp_data", rs1_data, 64'h22);
      check("byp_zero", rs2_hit, 0);
      idle();
      idle();
`endif

      // flush on a full queue with a concurrent push
      step(1, 4, 64'h444, 0, 3, 0, 1, 0);
      step(1, 6, 64'h666, 0, 3, 0, 1, 0);
      r0 = retired;
      step(1, 9, 64'h999, 0, 3, 0, 0, 1);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("flush_ready", in_ready, 1);
      check("flush_we", write_enable, 0);
      check("flush_retired", retired, r0);
      idle();

      // asynchronous reset with entries queued
      step(1, 10, 64'hAA, 0, 3, 0, 1, 0);
      step(1, 11, 64'hBB, 0, 3, 0, 1, 0);
      set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      check("mid_rst_we", write_enable, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_retired", retired, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      mq.delete();
      m_retired = '0;
      repeat (3) idle();

      // random traffic
      for (int n = 0; n < 400; n++) begin
`ifdef WB_BYPASS_EN
         rs1_addr = AW'($urandom_range(0, 7));
         rs2_addr = AW'($urandom_range(0, 7));
`endif
         step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)),
              {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'($urandom),
              $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
